// File: rtl/if_stage_pkg.sv
// ============================================================================
// if_stage_pkg : shared types, constants and fetch-state encodings for IF
// Rev 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam logic RST_ENABLE        = 1'b1;
  localparam logic IN_DELAY_SLOT     = 1'b1;
  localparam logic NOT_IN_DELAY_SLOT = 1'b0;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_addr_t ZERO_WORD        = '0;
  localparam inst_addr_t DEFAULT_RESET_PC = 32'h0000_0000;
  localparam inst_t      DEFAULT_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUF_FULL = 2'd1,
    DROP     = 2'd2
  } fetch_state_t;

  function automatic inst_addr_t seq_pc(input inst_addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_skid_buf.sv
// ============================================================================
// if_skid_buf : one-entry pc/inst holding buffer used while decode is stalled
// Rev 1.0
// ============================================================================
`default_nettype none

module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       drain,
  input  inst_addr_t load_pc,
  input  inst_t      load_inst,
  output logic       full,
  output inst_addr_t buf_pc,
  output inst_t      buf_inst
);

  // Clear wins over load, load wins over drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      full     <= 1'b0;
      buf_pc   <= ZERO_WORD;
      buf_inst <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full     <= 1'b1;
      buf_pc   <= load_pc;
      buf_inst <= load_inst;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : PC, instruction-memory handshake, skid buffer and IF/ID register
// Rev 1.0
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        next_inst_in_delayslot_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        is_in_delayslot_o
);

  fetch_state_t state, state_nxt;
  inst_addr_t   pc, pc_nxt;
  inst_addr_t   redirect_pc, redirect_pc_nxt;
  logic         redirect_vld, redirect_vld_nxt;
  logic         ds_pending, ds_pending_nxt;
  inst_addr_t   id_pc, id_pc_nxt;
  inst_t        id_inst, id_inst_nxt;
  logic         id_ds, id_ds_nxt;

  logic         xfer;
  logic         branch_acc;
  logic         ds_flag;
  logic         buf_clear, buf_load, buf_drain;
  logic         buf_full;
  inst_addr_t   buf_pc;
  inst_t        buf_inst;

  assign imem_req_o  = (rst != RST_ENABLE) && (state != BUF_FULL);
  assign imem_addr_o = (rst == RST_ENABLE) ? ZERO_WORD : pc;

  assign pc_o              = id_pc;
  assign inst_o            = id_inst;
  assign is_in_delayslot_o = id_ds;

  assign xfer       = imem_req_o && imem_ack_i;
  assign branch_acc = branch_flag_i && !stall_i && !flush_i && (state != DROP);
  // Delay-slot marking for whatever real instruction enters IF/ID this edge.
  assign ds_flag    = ds_pending || (branch_acc && next_inst_in_delayslot_i);

  if_skid_buf u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (buf_clear),
    .load      (buf_load),
    .drain     (buf_drain),
    .load_pc   (pc),
    .load_inst (imem_rdata_i),
    .full      (buf_full),
    .buf_pc    (buf_pc),
    .buf_inst  (buf_inst)
  );

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    redirect_pc_nxt  = redirect_pc;
    redirect_vld_nxt = redirect_vld;
    ds_pending_nxt   = ds_pending;
    id_pc_nxt        = id_pc;
    id_inst_nxt      = id_inst;
    id_ds_nxt        = id_ds;
    buf_clear        = 1'b0;
    buf_load         = 1'b0;
    buf_drain        = 1'b0;

    if (flush_i) begin
      id_pc_nxt      = ZERO_WORD;
      id_inst_nxt    = NOP_INST;
      id_ds_nxt      = NOT_IN_DELAY_SLOT;
      buf_clear      = 1'b1;
      ds_pending_nxt = 1'b0;
      if (imem_req_o && !imem_ack_i) begin
        // Address must stay put until the stale ack; the flush target rides
        // in the redirect register and is applied on that discarded transfer.
        state_nxt        = DROP;
        redirect_pc_nxt  = flush_pc_i;
        redirect_vld_nxt = 1'b1;
      end else begin
        state_nxt        = FETCH;
        pc_nxt           = flush_pc_i;
        redirect_vld_nxt = 1'b0;
      end
    end else begin
      if (xfer) begin
        pc_nxt           = redirect_vld ? redirect_pc : seq_pc(pc);
        redirect_vld_nxt = 1'b0;
      end

      // An outstanding un-acked request is the delay slot: defer the target.
      // Otherwise the delay slot is transferring now or already buffered.
      if (branch_acc) begin
        if (xfer || !imem_req_o) begin
          pc_nxt           = branch_target_i;
          redirect_vld_nxt = 1'b0;
        end else begin
          redirect_pc_nxt  = branch_target_i;
          redirect_vld_nxt = 1'b1;
        end
      end

      if (state == DROP) begin
        if (xfer) begin
          state_nxt = FETCH;
        end
        if (!stall_i) begin
          id_pc_nxt   = ZERO_WORD;
          id_inst_nxt = NOP_INST;
          id_ds_nxt   = NOT_IN_DELAY_SLOT;
        end
      end else if (!stall_i) begin
        if (buf_full) begin
          id_pc_nxt      = buf_pc;
          id_inst_nxt    = buf_inst;
          id_ds_nxt      = ds_flag;
          ds_pending_nxt = 1'b0;
          buf_drain      = 1'b1;
          state_nxt      = FETCH;
        end else if (xfer) begin
          id_pc_nxt      = pc;
          id_inst_nxt    = imem_rdata_i;
          id_ds_nxt      = ds_flag;
          ds_pending_nxt = 1'b0;
        end else begin
          id_pc_nxt      = ZERO_WORD;
          id_inst_nxt    = NOP_INST;
          id_ds_nxt      = NOT_IN_DELAY_SLOT;
          ds_pending_nxt = ds_flag;
        end
      end else if (xfer) begin
        buf_load  = 1'b1;
        state_nxt = BUF_FULL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      redirect_pc  <= ZERO_WORD;
      redirect_vld <= 1'b0;
      ds_pending   <= 1'b0;
      id_pc        <= ZERO_WORD;
      id_inst      <= NOP_INST;
      id_ds        <= NOT_IN_DELAY_SLOT;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      redirect_pc  <= redirect_pc_nxt;
      redirect_vld <= redirect_vld_nxt;
      ds_pending   <= ds_pending_nxt;
      id_pc        <= id_pc_nxt;
      id_inst      <= id_inst_nxt;
      id_ds        <= id_ds_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : directed self-checking bench for if_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        next_inst_in_delayslot_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        is_in_delayslot_o;

  int checks = 0;
  int errors = 0;
  logic saw_18 = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {8'hC0, a[23:0]};
  endfunction

  // Memory returns a word derived from its address.
  assign imem_rdata_i = inst_of(imem_addr_o);

  always @(posedge clk) begin
    if (imem_req_o && imem_addr_o == 32'h18) saw_18 = 1'b1;
  end

  if_stage dut (
    .clk                      (clk),
    .rst                      (rst),
    .stall_i                  (stall_i),
    .flush_i                  (flush_i),
    .flush_pc_i               (flush_pc_i),
    .branch_flag_i            (branch_flag_i),
    .branch_target_i          (branch_target_i),
    .next_inst_in_delayslot_i (next_inst_in_delayslot_i),
    .imem_req_o               (imem_req_o),
    .imem_addr_o              (imem_addr_o),
    .imem_ack_i               (imem_ack_i),
    .imem_rdata_i             (imem_rdata_i),
    .pc_o                     (pc_o),
    .inst_o                   (inst_o),
    .is_in_delayslot_o        (is_in_delayslot_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic ds);
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".inst"}, inst_o, inst);
    check({tag, ".ds"}, {31'd0, is_in_delayslot_o}, {31'd0, ds});
  endtask

  task automatic check_fetch(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"}, {31'd0, imem_req_o}, {31'd0, req});
    if (req) check({tag, ".addr"}, imem_addr_o, addr);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    flush_pc_i = 32'h0;
    branch_flag_i = 1'b0;
    branch_target_i = 32'h0;
    next_inst_in_delayslot_i = 1'b0;
    imem_ack_i = 1'b1;

    tick();
    tick();
    check_id("reset", 32'h0, 32'h0, 1'b0);
    check("reset.req", {31'd0, imem_req_o}, 32'd0);
    check("reset.addr", imem_addr_o, 32'h0);

    // Back-to-back fetch
    rst = 1'b0;
    #1;
    check_fetch("first", 1'b1, 32'h0);
    tick();
    check_id("b2b0", 32'h0, inst_of(32'h0), 1'b0);
    check_fetch("b2b0", 1'b1, 32'h4);
    tick();
    check_id("b2b4", 32'h4, inst_of(32'h4), 1'b0);
    check_fetch("b2b4", 1'b1, 32'h8);

    // Ack for 0x8 delayed two cycles
    imem_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_id("wait8", 32'h0, 32'h0, 1'b0);
      check_fetch("wait8", 1'b1, 32'h8);
    end
    imem_ack_i = 1'b1;
    tick();
    check_id("got8", 32'h8, inst_of(32'h8), 1'b0);
    check_fetch("got8", 1'b1, 32'hC);

    // Stall on the 0xC transfer: word goes to the skid buffer
    stall_i = 1'b1;
    tick();
    check_id("stallC", 32'h8, inst_of(32'h8), 1'b0);
    check_fetch("stallC", 1'b0, 32'h0);
    tick();
    check_id("stallC2", 32'h8, inst_of(32'h8), 1'b0);
    check_fetch("stallC2", 1'b0, 32'h0);
    stall_i = 1'b0;
    tick();
    check_id("drainC", 32'hC, inst_of(32'hC), 1'b0);
    check_fetch("drainC", 1'b1, 32'h10);
    tick();
    check_id("got10", 32'h10, inst_of(32'h10), 1'b0);
    check_fetch("got10", 1'b1, 32'h14);

    // Branch at 0x10 -> 0x100, delay slot fetched in the branch cycle
    branch_flag_i = 1'b1;
    branch_target_i = 32'h100;
    next_inst_in_delayslot_i = 1'b1;
    tick();
    branch_flag_i = 1'b0;
    next_inst_in_delayslot_i = 1'b0;
    check_id("ds14", 32'h14, inst_of(32'h14), 1'b1);
    check_fetch("ds14", 1'b1, 32'h100);
    tick();
    check_id("tgt100", 32'h100, inst_of(32'h100), 1'b0);
    check_fetch("tgt100", 1'b1, 32'h104);
    check("no_fetch_18", {31'd0, saw_18}, 32'd0);
    tick();
    check_id("got104", 32'h104, inst_of(32'h104), 1'b0);
    check_fetch("got104", 1'b1, 32'h108);

    // Branch at 0x104 -> 0x300 with the delay slot ack delayed 3 cycles
    branch_flag_i = 1'b1;
    branch_target_i = 32'h300;
    next_inst_in_delayslot_i = 1'b1;
    imem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      branch_flag_i = 1'b0;
      next_inst_in_delayslot_i = 1'b0;
      check_id("dswait", 32'h0, 32'h0, 1'b0);
      check_fetch("dswait", 1'b1, 32'h108);
    end
    imem_ack_i = 1'b1;
    tick();
    check_id("ds108", 32'h108, inst_of(32'h108), 1'b1);
    check_fetch("ds108", 1'b1, 32'h300);
    tick();
    check_id("tgt300", 32'h300, inst_of(32'h300), 1'b0);
    check_fetch("tgt300", 1'b1, 32'h304);

    // Flush while 0x304 is outstanding: stale data must be dropped
    imem_ack_i = 1'b0;
    tick();
    check_fetch("pend304", 1'b1, 32'h304);
    flush_i = 1'b1;
    flush_pc_i = 32'h200;
    tick();
    flush_i = 1'b0;
    check_id("flush", 32'h0, 32'h0, 1'b0);
    check_fetch("drop_hold", 1'b1, 32'h304);
    imem_ack_i = 1'b1;
    tick();
    check_id("dropped", 32'h0, 32'h0, 1'b0);
    check_fetch("refetch", 1'b1, 32'h200);
    tick();
    check_id("got200", 32'h200, inst_of(32'h200), 1'b0);
    check_fetch("got200", 1'b1, 32'h204);

    // Flush coinciding with an ack: that word is discarded, no drop
    flush_i = 1'b1;
    flush_pc_i = 32'h400;
    tick();
    flush_i = 1'b0;
    check_id("flushack", 32'h0, 32'h0, 1'b0);
    check_fetch("flushack", 1'b1, 32'h400);
    tick();
    check_id("got400", 32'h400, inst_of(32'h400), 1'b0);

    // Asynchronous reset pulsed mid-wait
    imem_ack_i = 1'b0;
    tick();
    check_fetch("pend404", 1'b1, 32'h404);
    #2;
    rst = 1'b1;
    #1;
    check_id("async_rst", 32'h0, 32'h0, 1'b0);
    check("async_rst.req", {31'd0, imem_req_o}, 32'd0);
    check("async_rst.addr", imem_addr_o, 32'h0);
    tick();
    rst = 1'b0;
    imem_ack_i = 1'b1;
    #1;
    check_fetch("restart", 1'b1, 32'h0);
    tick();
    check_id("restart0", 32'h0, inst_of(32'h0), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
